alu_share_arbiter: RTL

- Shares one combinational ALU instance between two requesters, e.g. the execute stage and a multi-cycle helper unit.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. A three-state FSM latches operands, drives the shared ALU for one cycle, registers the result and holds it until the owner accepts it.
- The block sits between the requesters and the `alu` instance, driving the ALU inputs and sampling its output.

---
 rtl/alu_share_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two valid/ready requesters.
// Each transaction goes IDLE (accept) -> EXEC (drive ALU) -> RESP (hold result until taken).
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_srca,
    input  logic [DATA_WIDTH-1:0]    req0_srcb,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [DATA_WIDTH-1:0]    rsp0_result,
    output logic                     rsp0_err,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_srca,
    input  logic [DATA_WIDTH-1:0]    req1_srcb,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [DATA_WIDTH-1:0]    rsp1_result,
    output logic                     rsp1_err,
    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_last_grant;
    logic                     r_owner;
    logic [DATA_WIDTH-1:0]    r_srca;
    logic [DATA_WIDTH-1:0]    r_srcb;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic [DATA_WIDTH-1:0]    r_result;
    logic                     r_err;
    logic                     w_gnt0;
    logic                     w_gnt1;
    logic                     w_rsp_ack;

    function automatic logic is_illegal(input logic [OPCODE_LENGTH-1:0] op);
        return (op == OPCODE_LENGTH'(4'b1101)) || (op == OPCODE_LENGTH'(4'b1111));
    endfunction

    assign w_rsp_ack = r_owner ? rsp1_ready : rsp0_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On contention the requester that did not win last time goes first.
                if (req0_valid && (!req1_valid || r_last_grant)) begin
                    w_gnt0 = 1'b1;
                end else if (req1_valid) begin
                    w_gnt1 = 1'b1;
                end
                if (w_gnt0 || w_gnt1) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: begin
                if (w_rsp_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_srca       <= '0;
            r_srcb       <= '0;
            r_op         <= '0;
            r_result     <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0 || w_gnt1) begin
                r_srca       <= w_gnt1 ? req1_srca : req0_srca;
                r_srcb       <= w_gnt1 ? req1_srcb : req0_srcb;
                r_op         <= w_gnt1 ? req1_op   : req0_op;
                r_owner      <= w_gnt1;
                r_last_grant <= w_gnt1;
            end
            if (r_state == S_EXEC) begin
                if (is_illegal(r_op)) begin
                    r_result <= '0;
                    r_err    <= 1'b1;
                end else begin
                    r_result <= alu_result;
                    r_err    <= 1'b0;
                end
            end
        end
    end

    // ALU inputs always come from the latched registers so they never follow requester ports.
    assign alu_srca    = r_srca;
    assign alu_srcb    = r_srcb;
    assign alu_op      = r_op;

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign busy        = (r_state != S_IDLE);

    assign rsp0_valid  = (r_state == S_RESP) && !r_owner;
    assign rsp1_valid  = (r_state == S_RESP) &&  r_owner;
    assign rsp0_result = rsp0_valid ? r_result : '0;
    assign rsp1_result = rsp1_valid ? r_result : '0;
    assign rsp0_err    = rsp0_valid && r_err;
    assign rsp1_err    = rsp1_valid && r_err;

endmodule
